multi_status: RTL and testbench

- AXI4-Lite status block for an NCH-channel packet-generator / Ethernet design.
- Synchronises each channel's "busy generating packets" and PCS-aligned inputs into clk.
- Detects loss-of-alignment events, latches them in write-1-to-clear sticky bits and counts them per channel.
- Drives per-channel green/orange LEDs, including a blink mode for "aligned now, but lost alignment since last clear".

---
 rtl/multi_status.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_multi_status.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_status.sv
// -----------------------------------------------------------------------------
// multi_status
//   AXI4-Lite status block for an NCH-channel packet generator / Ethernet
//   design. It synchronises each channel's busy and PCS-aligned flags into clk,
//   latches loss-of-alignment events in W1C sticky bits, counts them per
//   channel and drives per-channel green/orange LEDs.
//
// Ports
//   clk, resetn    clock, synchronous active-low reset
//   busy[NCH]      per-channel "generating packets" flag (asynchronous)
//   aligned[NCH]   per-channel PCS aligned flag (asynchronous)
//   led_green      per-channel busy LED
//   led_orange     per-channel alignment-fault LED
//   S_AXI_*        AXI4-Lite slave, AW-bit byte address, 32-bit data
//
// Register map (index = byte address / 4)
//   0 BUSY (RO)   1 ALIGN (RO)   2 STICKY (RW1C)   3 CTRL (RW)
//   4 NCH_ID (RO) 8+i COUNT_i (any write clears)
//   CTRL: bit0 CLEAR_ALL (self-clearing, reads 0), bits[31:16] LED_DISABLE.
//   Unmapped index -> DECERR, write to RO -> SLVERR.
//
// CNT_RESET is the reset value of the loss counters. It stays 0 in normal use;
// a nonzero value only shortens saturation testing.
// -----------------------------------------------------------------------------

// Two-flop synchroniser for one asynchronous bit. The flops are deliberately
// not reset so the synchronised value is valid while reset is still held.
module cdc_single (
  input  logic clk,
  input  logic din,
  output logic dout
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], din};

  always_ff @(posedge clk) sync_q <= sync_d;

  assign dout = sync_q[1];
endmodule

// AXI4-Lite slave core. Converts the five AXI channels into single-cycle
// ashi_write / ashi_read strobes towards the register logic.
//
// Handshake: every AXI transfer happens on a clk edge where VALID and READY are
// both high; VALID, once raised, holds its payload until that edge. AW and W
// are accepted independently, then one ashi_write strobe is issued, and B is
// raised once the register side reports idle again (ashi_widle). A read issues
// one ashi_read strobe; the register side registers data in that cycle and R
// presents it in the next.
module axi4_lite_slave #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] S_AXI_AWADDR,
  input  logic          S_AXI_AWVALID,
  output logic          S_AXI_AWREADY,
  input  logic [31:0]   S_AXI_WDATA,
  input  logic          S_AXI_WVALID,
  output logic          S_AXI_WREADY,
  output logic [1:0]    S_AXI_BRESP,
  output logic          S_AXI_BVALID,
  input  logic          S_AXI_BREADY,
  input  logic [AW-1:0] S_AXI_ARADDR,
  input  logic          S_AXI_ARVALID,
  output logic          S_AXI_ARREADY,
  output logic [31:0]   S_AXI_RDATA,
  output logic [1:0]    S_AXI_RRESP,
  output logic          S_AXI_RVALID,
  input  logic          S_AXI_RREADY,
  output logic          ashi_write,
  output logic [AW-1:0] ashi_waddr,
  output logic [31:0]   ashi_wdata,
  input  logic [1:0]    ashi_wresp,
  input  logic          ashi_widle,
  output logic          ashi_read,
  output logic [AW-1:0] ashi_raddr,
  input  logic [31:0]   ashi_rdata,
  input  logic [1:0]    ashi_rresp,
  input  logic          ashi_ridle
);
  typedef enum logic [1:0] {WS_ADDR, WS_EXEC, WS_WAIT, WS_RESP} ws_e;
  typedef enum logic [1:0] {RS_ADDR, RS_EXEC, RS_RESP} rs_e;

  ws_e           ws_q;
  rs_e           rs_q;
  logic          aw_got_q;
  logic          w_got_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    bresp_q;
  logic [AW-1:0] raddr_q;

  // Write side: collect AW and W in any order, strobe once, wait for idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_q     <= WS_ADDR;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      bresp_q  <= 2'b00;
    end else begin
      case (ws_q)
        WS_ADDR: begin
          if (S_AXI_AWVALID && !aw_got_q) begin
            aw_got_q <= 1'b1;
            waddr_q  <= S_AXI_AWADDR;
          end
          if (S_AXI_WVALID && !w_got_q) begin
            w_got_q <= 1'b1;
            wdata_q <= S_AXI_WDATA;
          end
          if ((aw_got_q || S_AXI_AWVALID) && (w_got_q || S_AXI_WVALID) && ashi_widle)
            ws_q <= WS_EXEC;
        end
        WS_EXEC: begin
          aw_got_q <= 1'b0;
          w_got_q  <= 1'b0;
          ws_q     <= WS_WAIT;
        end
        WS_WAIT: begin
          if (ashi_widle) begin
            bresp_q <= ashi_wresp;
            ws_q    <= WS_RESP;
          end
        end
        WS_RESP: begin
          if (S_AXI_BREADY) ws_q <= WS_ADDR;
        end
        default: ws_q <= WS_ADDR;
      endcase
    end
  end

  assign S_AXI_AWREADY = (ws_q == WS_ADDR) && !aw_got_q;
  assign S_AXI_WREADY  = (ws_q == WS_ADDR) && !w_got_q;
  assign S_AXI_BVALID  = (ws_q == WS_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign ashi_write    = (ws_q == WS_EXEC);
  assign ashi_waddr    = waddr_q;
  assign ashi_wdata    = wdata_q;

  // Read side: accept address, strobe once, present registered data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rs_q    <= RS_ADDR;
      raddr_q <= '0;
    end else begin
      case (rs_q)
        RS_ADDR: begin
          if (S_AXI_ARVALID && ashi_ridle) begin
            raddr_q <= S_AXI_ARADDR;
            rs_q    <= RS_EXEC;
          end
        end
        RS_EXEC: rs_q <= RS_RESP;
        RS_RESP: begin
          if (S_AXI_RREADY) rs_q <= RS_ADDR;
        end
        default: rs_q <= RS_ADDR;
      endcase
    end
  end

  assign S_AXI_ARREADY = (rs_q == RS_ADDR) && ashi_ridle;
  assign S_AXI_RVALID  = (rs_q == RS_RESP);
  assign S_AXI_RDATA   = ashi_rdata;
  assign S_AXI_RRESP   = ashi_rresp;
  assign ashi_read     = (rs_q == RS_EXEC);
  assign ashi_raddr    = raddr_q;
endmodule

module multi_status #(
  parameter int          NCH            = 2,
  parameter int          AW             = 8,
  parameter int          ACTIVE_LOW_LED = 0,
  parameter int          BLINK_DIV      = 25,
  parameter logic [15:0] CNT_RESET      = 16'h0000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [NCH-1:0] busy,
  input  logic [NCH-1:0] aligned,
  output logic [NCH-1:0] led_green,
  output logic [NCH-1:0] led_orange,
  input  logic [AW-1:0]  S_AXI_AWADDR,
  input  logic [2:0]     S_AXI_AWPROT,
  input  logic           S_AXI_AWVALID,
  output logic           S_AXI_AWREADY,
  input  logic [31:0]    S_AXI_WDATA,
  input  logic [3:0]     S_AXI_WSTRB,
  input  logic           S_AXI_WVALID,
  output logic           S_AXI_WREADY,
  output logic [1:0]     S_AXI_BRESP,
  output logic           S_AXI_BVALID,
  input  logic           S_AXI_BREADY,
  input  logic [AW-1:0]  S_AXI_ARADDR,
  input  logic [2:0]     S_AXI_ARPROT,
  input  logic           S_AXI_ARVALID,
  output logic           S_AXI_ARREADY,
  output logic [31:0]    S_AXI_RDATA,
  output logic [1:0]     S_AXI_RRESP,
  output logic           S_AXI_RVALID,
  input  logic           S_AXI_RREADY
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // ---------------------------------------------------------------- AXI core
  logic          ashi_write;
  logic [AW-1:0] ashi_waddr;
  logic [31:0]   ashi_wdata;
  logic [1:0]    ashi_wresp;
  logic          ashi_widle;
  logic          ashi_read;
  logic [AW-1:0] ashi_raddr;
  logic [31:0]   ashi_rdata;
  logic [1:0]    ashi_rresp;
  logic          ashi_ridle;

  axi4_lite_slave #(.AW(AW)) u_axi (
    .clk           (clk),
    .resetn        (resetn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .ashi_write    (ashi_write),
    .ashi_waddr    (ashi_waddr),
    .ashi_wdata    (ashi_wdata),
    .ashi_wresp    (ashi_wresp),
    .ashi_widle    (ashi_widle),
    .ashi_read     (ashi_read),
    .ashi_raddr    (ashi_raddr),
    .ashi_rdata    (ashi_rdata),
    .ashi_rresp    (ashi_rresp),
    .ashi_ridle    (ashi_ridle)
  );

  // Protection bits, byte strobes and the byte offset inside a word carry no
  // meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                       ashi_waddr[1:0], ashi_raddr[1:0]};

  // ----------------------------------------------------------- synchronisers
  logic [NCH-1:0] busy_s;
  logic [NCH-1:0] align_s;

  for (genvar g = 0; g < NCH; g++) begin : gen_sync
    cdc_single u_busy  (.clk(clk), .din(busy[g]),    .dout(busy_s[g]));
    cdc_single u_align (.clk(clk), .din(aligned[g]), .dout(align_s[g]));
  end

  // ------------------------------------------------------------- state regs
  logic [NCH-1:0]   align_q, align_d;
  logic [NCH-1:0]   sticky_q, sticky_d;
  logic [15:0]      ctrl_dis_q, ctrl_dis_d;
  logic             clr_q, clr_d;
  logic [BLINK_DIV:0] blink_q, blink_d;
  logic [15:0]      cnt_q [NCH];
  logic [15:0]      cnt_d [NCH];
  logic [NCH-1:0]   lost;

  // One-cycle pulse per falling edge of the synchronised aligned flag.
  assign lost = align_q & ~align_s;

  // -------------------------------------------------------------- write FSM
  typedef enum logic {W_IDLE, W_DONE} wst_e;
  wst_e       wst_q;
  logic [1:0] wresp_q;
  logic       wr_en;

  assign wr_en      = ashi_write && (wst_q == W_IDLE);
  assign ashi_widle = (wst_q == W_IDLE) && !ashi_write;
  assign ashi_wresp = wresp_q;
  assign ashi_ridle = 1'b1;

  // Write address decode.
  logic [31:0]    widx;
  logic [1:0]     wr_resp;
  logic           wr_sticky;
  logic           wr_ctrl;
  logic [NCH-1:0] wr_cnt;

  assign widx = 32'(ashi_waddr[AW-1:2]);

  always_comb begin
    wr_resp   = RESP_DECERR;
    wr_sticky = 1'b0;
    wr_ctrl   = 1'b0;
    wr_cnt    = '0;
    case (widx)
      32'd0, 32'd1, 32'd4: wr_resp = RESP_SLVERR;
      32'd2: begin
        wr_resp   = RESP_OKAY;
        wr_sticky = 1'b1;
      end
      32'd3: begin
        wr_resp = RESP_OKAY;
        wr_ctrl = 1'b1;
      end
      default: ;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (widx == 32'(8 + i)) begin
        wr_resp   = RESP_OKAY;
        wr_cnt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wst_q   <= W_IDLE;
      wresp_q <= RESP_OKAY;
    end else begin
      case (wst_q)
        W_IDLE: begin
          if (ashi_write) begin
            wresp_q <= wr_resp;
            wst_q   <= W_DONE;
          end
        end
        W_DONE:  wst_q <= W_IDLE;
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- next-state logic
  // A loss event always wins over a same-cycle clear, for both the sticky
  // bit and the counter, so no event can be silently dropped.
  always_comb begin
    align_d    = align_s;
    blink_d    = blink_q + {{BLINK_DIV{1'b0}}, 1'b1};

    sticky_d = sticky_q;
    if (wr_en && wr_sticky) sticky_d = sticky_d & ~ashi_wdata[NCH-1:0];
    if (clr_q) sticky_d = '0;
    sticky_d = sticky_d | lost;

    ctrl_dis_d = ctrl_dis_q;
    clr_d      = 1'b0;
    if (wr_en && wr_ctrl) begin
      ctrl_dis_d = ashi_wdata[31:16];
      clr_d      = ashi_wdata[0];
    end

    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_q || (wr_en && wr_cnt[i])) cnt_d[i] = 16'h0000;
      if (lost[i] && (cnt_d[i] != 16'hFFFF)) cnt_d[i] = cnt_d[i] + 16'd1;
    end
  end

  // align_q loads the current synchronised value during reset so that the
  // release of reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      align_q    <= align_s;
      sticky_q   <= '0;
      ctrl_dis_q <= '0;
      clr_q      <= 1'b0;
      blink_q    <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= CNT_RESET;
    end else begin
      align_q    <= align_d;
      sticky_q   <= sticky_d;
      ctrl_dis_q <= ctrl_dis_d;
      clr_q      <= clr_d;
      blink_q    <= blink_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // --------------------------------------------------------------- read path
  // Data is taken from the registered state, i.e. the value before any update
  // happening in the same cycle.
  logic [31:0] ridx;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  assign ridx = 32'(ashi_raddr[AW-1:2]);

  always_comb begin
    rd_data = 32'h0;
    rd_resp = RESP_DECERR;
    case (ridx)
      32'd0: begin rd_data = 32'(busy_s);          rd_resp = RESP_OKAY; end
      32'd1: begin rd_data = 32'(align_s);         rd_resp = RESP_OKAY; end
      32'd2: begin rd_data = 32'(sticky_q);        rd_resp = RESP_OKAY; end
      32'd3: begin rd_data = {ctrl_dis_q, 16'h0};  rd_resp = RESP_OKAY; end
      32'd4: begin rd_data = 32'(NCH);             rd_resp = RESP_OKAY; end
      default: ;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (ridx == 32'(8 + i)) begin
        rd_data = {16'h0, cnt_q[i]};
        rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= 32'h0;
      rresp_q <= RESP_OKAY;
    end else if (ashi_read) begin
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
    end
  end

  assign ashi_rdata = rdata_q;
  assign ashi_rresp = rresp_q;

  // -------------------------------------------------------------------- LEDs
  // Orange: solid while unaligned; blinking while aligned but a loss has been
  // latched since the last clear.
  logic           blink_phase;
  logic [NCH-1:0] led_en;
  logic [NCH-1:0] green_raw;
  logic [NCH-1:0] orange_raw;

  assign blink_phase = blink_q[BLINK_DIV];
  assign led_en      = ~ctrl_dis_q[NCH-1:0];
  assign green_raw   = busy_s & led_en;
  assign orange_raw  = (~align_s | (sticky_q & {NCH{blink_phase}})) & led_en;

  assign led_green  = (ACTIVE_LOW_LED != 0) ? ~green_raw  : green_raw;
  assign led_orange = (ACTIVE_LOW_LED != 0) ? ~orange_raw : orange_raw;
endmodule

// File: tb/tb_multi_status.sv
// -----------------------------------------------------------------------------
// tb_multi_status
//   Directed bench for multi_status. Two instances share one AXI master:
//   dut0: NCH=2, active-high LEDs, counters reset to 0.
//   dut1: NCH=4, active-low LEDs, counters reset to 0xFFFB.
//   'sel' routes the master to one of them. BLINK_DIV=4 on both.
// -----------------------------------------------------------------------------
module tb_multi_status;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------- shared master
  logic        sel     = 1'b0;
  logic [7:0]  awaddr  = '0;
  logic [7:0]  araddr  = '0;
  logic [31:0] wdata   = '0;
  logic        awvalid = 1'b0;
  logic        wvalid  = 1'b0;
  logic        bready  = 1'b0;
  logic        arvalid = 1'b0;
  logic        rready  = 1'b0;

  logic [1:0] busy0 = 2'b00, aligned0 = 2'b11;
  logic [3:0] busy1 = 4'h0,  aligned1 = 4'hF;
  logic [1:0] led_green0, led_orange0;
  logic [3:0] led_green1, led_orange1;

  logic        aw_rdy0, w_rdy0, b_vld0, ar_rdy0, r_vld0;
  logic        aw_rdy1, w_rdy1, b_vld1, ar_rdy1, r_vld1;
  logic [1:0]  b_resp0, r_resp0, b_resp1, r_resp1;
  logic [31:0] r_data0, r_data1;

  logic        aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;
  assign aw_rdy = sel ? aw_rdy1 : aw_rdy0;
  assign w_rdy  = sel ? w_rdy1  : w_rdy0;
  assign b_vld  = sel ? b_vld1  : b_vld0;
  assign b_resp = sel ? b_resp1 : b_resp0;
  assign ar_rdy = sel ? ar_rdy1 : ar_rdy0;
  assign r_vld  = sel ? r_vld1  : r_vld0;
  assign r_resp = sel ? r_resp1 : r_resp0;
  assign r_data = sel ? r_data1 : r_data0;

  multi_status #(.NCH(2), .AW(8), .ACTIVE_LOW_LED(0), .BLINK_DIV(4),
                 .CNT_RESET(16'h0000)) dut0 (
    .clk(clk), .resetn(resetn), .busy(busy0), .aligned(aligned0),
    .led_green(led_green0), .led_orange(led_orange0),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & ~sel),
    .S_AXI_AWREADY(aw_rdy0), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF),
    .S_AXI_WVALID(wvalid & ~sel), .S_AXI_WREADY(w_rdy0), .S_AXI_BRESP(b_resp0),
    .S_AXI_BVALID(b_vld0), .S_AXI_BREADY(bready & ~sel), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & ~sel), .S_AXI_ARREADY(ar_rdy0),
    .S_AXI_RDATA(r_data0), .S_AXI_RRESP(r_resp0), .S_AXI_RVALID(r_vld0),
    .S_AXI_RREADY(rready & ~sel)
  );

  multi_status #(.NCH(4), .AW(8), .ACTIVE_LOW_LED(1), .BLINK_DIV(4),
                 .CNT_RESET(16'hFFFB)) dut1 (
    .clk(clk), .resetn(resetn), .busy(busy1), .aligned(aligned1),
    .led_green(led_green1), .led_orange(led_orange1),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & sel),
    .S_AXI_AWREADY(aw_rdy1), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF),
    .S_AXI_WVALID(wvalid & sel), .S_AXI_WREADY(w_rdy1), .S_AXI_BRESP(b_resp1),
    .S_AXI_BVALID(b_vld1), .S_AXI_BREADY(bready & sel), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & sel), .S_AXI_ARREADY(ar_rdy1),
    .S_AXI_RDATA(r_data1), .S_AXI_RRESP(r_resp1), .S_AXI_RVALID(r_vld1),
    .S_AXI_RREADY(rready & sel)
  );

  // ------------------------------------------------------------ driver tasks
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
    int   n;
    logic a_hs, w_hs;
    @(negedge clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      a_hs = awvalid && aw_rdy;
      w_hs = wvalid && w_rdy;
      @(negedge clk);
      n++;
      if (a_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
    end
    n = 0;
    while (!b_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    resp = b_resp;
    if (!b_vld) begin
      checks++; errors++;
      $display("FAIL axi_write_timeout addr=%h got no BVALID, required BVALID within 50 cycles", addr);
    end
    @(negedge clk);
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      if (ar_rdy) begin
        @(negedge clk);
        arvalid = 1'b0;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    n = 0;
    while (!r_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    data = r_data;
    resp = r_resp;
    if (!r_vld) begin
      checks++; errors++;
      $display("FAIL axi_read_timeout addr=%h got no RVALID, required RVALID within 50 cycles", addr);
    end
    @(negedge clk);
    rready = 1'b0; arvalid = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (led_orange0 !== 2'b00) begin errors++; $display("FAIL rst_orange0 got=%b exp=00", led_orange0); end
    checks++; if (led_green0 !== 2'b00) begin errors++; $display("FAIL rst_green0 got=%b exp=00", led_green0); end
    checks++; if (led_orange1 !== 4'hF) begin errors++; $display("FAIL rst_orange1 got=%b exp=1111", led_orange1); end
    checks++; if (led_green1 !== 4'hF) begin errors++; $display("FAIL rst_green1 got=%b exp=1111", led_green1); end
    sel = 1'b0;
    axi_read(8'h08, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL rst_sticky got=%h/%b exp=0/00", d, r); end
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count0 got=%h exp=0", d); end
    axi_read(8'h24, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count1 got=%h exp=0", d); end
    axi_read(8'h04, d, r);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL rst_align got=%h exp=3", d); end
    axi_read(8'h0C, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got=%h exp=0", d); end
    sel = 1'b1;
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h0000FFFB) begin errors++; $display("FAIL rst_count_preload got=%h exp=0000fffb", d); end
    axi_read(8'h04, d, r);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL rst_align1 got=%h exp=f", d); end
    sel = 1'b0;
  endtask

  task automatic test_align_loss();
    logic [31:0] d;
    logic [1:0]  r;
    logic        prev;
    int          n;
    sel = 1'b0;
    @(negedge clk); aligned0[1] = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (led_orange0 !== 2'b10) begin errors++; $display("FAIL loss_orange_down got=%b exp=10", led_orange0); end
    aligned0[1] = 1'b1;
    repeat (4) @(negedge clk);
    axi_read(8'h08, d, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL loss_sticky got=%h exp=2", d); end
    axi_read(8'h24, d, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL loss_count1 got=%h exp=1", d); end
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL loss_count0 got=%h exp=0", d); end
    // Aligned again with a latched loss: orange[1] toggles every 16 cycles.
    prev = led_orange0[1];
    n = 0;
    while (led_orange0[1] === prev && n < 40) begin @(negedge clk); n++; end
    for (int k = 0; k < 2; k++) begin
      prev = led_orange0[1];
      n = 0;
      do begin @(negedge clk); n++; end while (led_orange0[1] === prev && n < 40);
      checks++; if (n !== 16) begin errors++; $display("FAIL blink_half_period got=%0d cycles exp=16", n); end
    end
    checks++; if (led_orange0[0] !== 1'b0) begin errors++; $display("FAIL blink_ch0_quiet got=%b exp=0", led_orange0[0]); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    logic [1:0]  r;
    sel = 1'b0;
    // Dropping one negedge ahead of the write start makes the lost pulse land
    // in the same cycle as the W1C strobe.
    @(negedge clk); aligned0[1] = 1'b0;
    axi_write(8'h08, 32'h2, r);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL w1c_resp got=%b exp=00", r); end
    aligned0[1] = 1'b1;
    repeat (4) @(negedge clk);
    axi_read(8'h08, d, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_collide_sticky got=%h exp=2", d); end
    axi_read(8'h24, d, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_collide_count1 got=%h exp=2", d); end
    axi_write(8'h08, 32'h2, r);
    axi_read(8'h08, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=0", d); end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    logic [1:0]  r;
    sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); aligned1[0] = 1'b0;
      repeat (6) @(negedge clk); aligned1[0] = 1'b1;
      repeat (6) @(negedge clk);
    end
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h0000FFFE) begin errors++; $display("FAIL sat_fffe got=%h exp=0000fffe", d); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); aligned1[0] = 1'b0;
      repeat (6) @(negedge clk); aligned1[0] = 1'b1;
      repeat (6) @(negedge clk);
    end
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h0000FFFF) begin errors++; $display("FAIL sat_ffff got=%h exp=0000ffff", d); end
    axi_write(8'h20, 32'h1234, r);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL sat_clr_resp got=%b exp=00", r); end
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sat_clr got=%h exp=0", d); end
    axi_read(8'h08, d, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL sat_sticky got=%h exp=1", d); end
    sel = 1'b0;
  endtask

  task automatic test_bad_access();
    logic [31:0] d;
    logic [1:0]  r;
    sel = 1'b0;
    axi_read(8'h14, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b11) begin errors++; $display("FAIL rd_idx5 got=%h/%b exp=0/11", d, r); end
    axi_write(8'h00, 32'hFFFF_FFFF, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_busy_ro got=%b exp=10", r); end
    axi_write(8'h14, 32'h1, r);
    checks++; if (r !== 2'b11) begin errors++; $display("FAIL wr_idx5 got=%b exp=11", r); end
    axi_read(8'h28, d, r);
    checks++; if (r !== 2'b11) begin errors++; $display("FAIL rd_count2_nch2 got=%b exp=11", r); end
    axi_read(8'h10, d, r);
    checks++; if (d !== 32'h2 || r !== 2'b00) begin errors++; $display("FAIL nch_id0 got=%h/%b exp=2/00", d, r); end
    sel = 1'b1;
    axi_read(8'h10, d, r);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL nch_id1 got=%h exp=4", d); end
    axi_read(8'h2C, d, r);
    checks++; if (d !== 32'h0000FFFB || r !== 2'b00) begin errors++; $display("FAIL count3_nch4 got=%h/%b exp=0000fffb/00", d, r); end
    sel = 1'b0;
  endtask

  task automatic test_led_ctrl();
    logic [31:0] d;
    logic [1:0]  r;
    sel = 1'b0;
    @(negedge clk); busy0 = 2'b01;
    repeat (4) @(negedge clk);
    checks++; if (led_green0 !== 2'b01) begin errors++; $display("FAIL green_on got=%b exp=01", led_green0); end
    axi_write(8'h0C, 32'h0001_0000, r);
    checks++; if (led_green0 !== 2'b00) begin errors++; $display("FAIL green_disabled got=%b exp=00", led_green0); end
    axi_read(8'h0C, d, r);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL ctrl_rd got=%h exp=00010000", d); end
    sel = 1'b1;
    @(negedge clk); busy1 = 4'b0001;
    repeat (4) @(negedge clk);
    checks++; if (led_green1 !== 4'b1110) begin errors++; $display("FAIL green1_on got=%b exp=1110", led_green1); end
    axi_write(8'h0C, 32'h0001_0000, r);
    checks++; if (led_green1 !== 4'b1111) begin errors++; $display("FAIL green1_disabled got=%b exp=1111", led_green1); end
    checks++; if (led_orange1[0] !== 1'b1) begin errors++; $display("FAIL orange1_disabled got=%b exp=1", led_orange1[0]); end
    sel = 1'b0;
  endtask

  task automatic test_clear_all();
    logic [31:0] d;
    logic [1:0]  r;
    sel = 1'b0;
    @(negedge clk); aligned0[0] = 1'b0;
    repeat (6) @(negedge clk); aligned0[0] = 1'b1;
    repeat (4) @(negedge clk);
    axi_read(8'h08, d, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pre_clr_sticky got=%h exp=1", d); end
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pre_clr_count0 got=%h exp=1", d); end
    axi_write(8'h0C, 32'h0001_0001, r);
    axi_read(8'h08, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_sticky got=%h exp=0", d); end
    axi_read(8'h20, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_count0 got=%h exp=0", d); end
    axi_read(8'h24, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_count1 got=%h exp=0", d); end
    axi_read(8'h0C, d, r);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL clr_ctrl_rd got=%h exp=00010000", d); end
  endtask

  initial begin
    test_reset();
    test_align_loss();
    test_w1c_collision();
    test_saturate();
    test_bad_access();
    test_led_ctrl();
    test_clear_all();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
